settings_writer: RTL and testbench
==================================

# settings_writer

Front-end writer for the settings register bank. Collects a four-word settings transaction (max row, max col, data min, data max) from the upstream number parser over a valid/ready stream, validates it, and issues a single-cycle write strobe with all four values to the settings store. Rejected or timed-out transactions never produce a write, so the stored settings always remain legal.

## Interface
- ROW_LIMIT, 32: largest legal max_row value.
- COL_LIMIT, 32: largest legal max_col value.
- TIMEOUT_CYCLES, 100_000_000: idle cycles allowed between accepted words before abort.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  pulse; begins a transaction when idle.
- in_valid  in  1  upstream word valid.
- in_data  in  32  upstream word.
- in_ready  out  1  block can accept a word.
- wr_en  out  1  one-cycle write strobe to the settings store.
- set_max_row  out  32  committed row value.
- set_max_col  out  32  committed col value.
- data_min  out  32  committed minimum, two's complement.
- data_max  out  32  committed maximum, two's complement.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse on successful commit.
- error  out  1  one-cycle pulse on rejection.
- err_code  out  2  0 none, 1 row/col out of range, 2 min > max, 3 timeout; held until next start.

## Operation
- FSM states: IDLE, GET_ROW, GET_COL, GET_MIN, GET_MAX, CHECK, COMMIT.
- IDLE: start=1 -> GET_ROW, clear err_code and timeout counter. Any other input is ignored.
- GET_*: in_ready=1. Handshake in_valid&in_ready captures in_data into a shadow register and advances: ROW->COL->MIN->MAX->CHECK.
- Shadow registers are separate from the output registers; outputs change only in COMMIT.
- CHECK (1 cycle, in_ready=0): row in 1..ROW_LIMIT and col in 1..COL_LIMIT (unsigned compare); else err_code=1. If range is OK, a signed compare min > max sets err_code=2. Range has priority over order. Pass -> COMMIT; fail -> error=1 for one cycle, return to IDLE.
- COMMIT (1 cycle): output registers load the shadow values. wr_en=1 and done=1 in the same cycle as the new outputs. Then IDLE.
- start while busy: ignored and does not restart. in_valid outside GET_*: not consumed.
- busy=1 in every state except IDLE.

## Timing
- Reset values: in_ready=0, wr_en=0, done=0, error=0, busy=0, err_code=0, set_max_row=5, set_max_col=5, data_min=1, data_max=9. State is IDLE and the shadow registers are cleared.
- start sampled at edge N: in_ready=1 from N+1.
- Fourth word accepted at edge N: CHECK during N+1. wr_en/done (or error) is asserted during N+2. in_ready returns to 0 at N+1.
- Minimum transaction: 1 + 4 + 2 = 7 cycles with back-to-back valid.
- Reset mid-transaction: immediate return to IDLE with reset output values. No partial write is ever issued.
- Outputs are registered, with no combinational path from inputs to outputs except none (in_ready is decoded from state only).

## Configuration
- SETTINGS_WRITER_TIMEOUT_EN defined: in GET_* a counter increments each cycle without a handshake and resets on each handshake. When the count reaches TIMEOUT_CYCLES-1 the block sets err_code=3, pulses error, and returns to IDLE.
- Not defined: no counter is synthesized, GET_* states wait indefinitely, and err_code=3 is never produced.

## Test plan
- Reset, then no stimulus -> outputs read 5/5/1/9, wr_en=0, busy=0, in_ready=0.
- start, then words 8,6,-3,20 back-to-back -> exactly one wr_en pulse 2 cycles after the 4th accept, with outputs 8/6/0xFFFFFFFD/20. done is coincident with wr_en; err_code=0.
- start, then words 0,4,1,2 -> error pulse, err_code=1, no wr_en, outputs unchanged. Repeat with 33,4,1,2 -> err_code=1.
- start, then words 4,4,10,-10 -> err_code=2, no wr_en. A second start mid-transaction (after word 2) has no effect on sequencing.
- With SETTINGS_WRITER_TIMEOUT_EN and TIMEOUT_CYCLES=16: start, one word, then in_valid=0 -> error on the 16th idle cycle, err_code=3. A subsequent valid transaction commits normally.
- rst_n asserted during GET_MAX, with in_valid randomly toggled throughout -> immediate IDLE and reset values. No wr_en at any point; new transaction after release succeeds.

Source files
------------

// File: rtl/settings_writer.sv
// ============================================================================
// Module   : settings_writer
// Purpose  : Collects a four-word settings transaction (max row, max col,
//            data min, data max), validates it and commits it to the
//            settings store with a one-cycle write strobe.
//            Optional idle timeout: define SETTINGS_WRITER_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module settings_writer #(
    parameter int unsigned ROW_LIMIT      = 32,
    parameter int unsigned COL_LIMIT      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] set_max_row,
    output logic [31:0] set_max_col,
    output logic [31:0] data_min,
    output logic [31:0] data_max,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_ROW = 3'd1,
        S_GET_COL = 3'd2,
        S_GET_MIN = 3'd3,
        S_GET_MAX = 3'd4,
        S_CHECK   = 3'd5,
        S_COMMIT  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_row;
    logic [31:0] r_col;
    logic [31:0] r_min;
    logic [31:0] r_max;
    logic        w_get;
    logic        w_hs;
    logic        w_range_bad;
    logic        w_order_bad;
    logic        w_timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_guard
        $error("settings_writer: TIMEOUT_CYCLES must be at least 2");
    end

    assign w_get       = (r_state == S_GET_ROW) || (r_state == S_GET_COL) ||
                         (r_state == S_GET_MIN) || (r_state == S_GET_MAX);
    assign w_hs        = w_get && in_valid;
    assign in_ready    = w_get;
    assign busy        = (r_state != S_IDLE);
    assign w_range_bad = (r_row == 32'd0) || (r_row > ROW_LIMIT) ||
                         (r_col == 32'd0) || (r_col > COL_LIMIT);
    assign w_order_bad = $signed(r_min) > $signed(r_max);

`ifdef SETTINGS_WRITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Abort on the edge where the idle count would reach TIMEOUT_CYCLES-1.
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_timeout  = w_get && !in_valid && (w_cnt_next == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE && start) || w_hs) begin
            r_cnt <= '0;
        end else if (w_get) begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_next = S_GET_ROW;
            S_GET_ROW: if (w_hs) w_state_next = S_GET_COL; else if (w_timeout) w_state_next = S_IDLE;
            S_GET_COL: if (w_hs) w_state_next = S_GET_MIN; else if (w_timeout) w_state_next = S_IDLE;
            S_GET_MIN: if (w_hs) w_state_next = S_GET_MAX; else if (w_timeout) w_state_next = S_IDLE;
            S_GET_MAX: if (w_hs) w_state_next = S_CHECK;   else if (w_timeout) w_state_next = S_IDLE;
            S_CHECK:   w_state_next = (w_range_bad || w_order_bad) ? S_IDLE : S_COMMIT;
            S_COMMIT:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Shadow registers hold the transaction until it has been validated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_min <= '0;
            r_max <= '0;
        end else if (w_hs) begin
            case (r_state)
                S_GET_ROW: r_row <= in_data;
                S_GET_COL: r_col <= in_data;
                S_GET_MIN: r_min <= in_data;
                S_GET_MAX: r_max <= in_data;
                default:   ;
            endcase
        end
    end

    // Outputs load on the CHECK->COMMIT edge so they are valid alongside wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en       <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'd0;
            set_max_row <= 32'd5;
            set_max_col <= 32'd5;
            data_min    <= 32'd1;
            data_max    <= 32'd9;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            if (r_state == S_IDLE && start) begin
                err_code <= 2'd0;
            end
            if (w_timeout) begin
                error    <= 1'b1;
                err_code <= 2'd3;
            end
            if (r_state == S_CHECK) begin
                if (w_range_bad) begin
                    error    <= 1'b1;
                    err_code <= 2'd1;
                end else if (w_order_bad) begin
                    error    <= 1'b1;
                    err_code <= 2'd2;
                end else begin
                    wr_en       <= 1'b1;
                    done        <= 1'b1;
                    set_max_row <= r_row;
                    set_max_col <= r_col;
                    data_min    <= r_min;
                    data_max    <= r_max;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_settings_writer.sv
// ============================================================================
// Module   : tb_settings_writer
// Purpose  : Directed self-checking bench for settings_writer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_settings_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] set_max_row;
    logic [31:0] set_max_col;
    logic [31:0] data_min;
    logic [31:0] data_max;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;

    settings_writer #(
        .ROW_LIMIT      (32),
        .COL_LIMIT      (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .set_max_row (set_max_row),
        .set_max_col (set_max_col),
        .data_min    (data_min),
        .data_max    (data_max),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en) wr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one full transaction with back-to-back words and checks its outcome.
    task automatic txn(input string name,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3,
                       input bit restart, input bit ok, input logic [1:0] code,
                       input logic [31:0] er, input logic [31:0] ec,
                       input logic [31:0] emn, input logic [31:0] emx);
        logic [31:0] w [4];
        int          wr0;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        wr0  = wr_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({name, ".ready"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            if (restart && i == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        check({name, ".chk_ready"}, 32'(in_ready), 32'd0);
        check({name, ".chk_wr"}, 32'(wr_en), 32'd0);
        @(negedge clk);
        check({name, ".wr"}, 32'(wr_en), 32'(ok));
        check({name, ".done"}, 32'(done), 32'(ok));
        check({name, ".err"}, 32'(error), 32'(!ok));
        check({name, ".code"}, 32'(err_code), 32'(code));
        check({name, ".row"}, set_max_row, er);
        check({name, ".col"}, set_max_col, ec);
        check({name, ".min"}, data_min, emn);
        check({name, ".max"}, data_max, emx);
        @(negedge clk);
        @(negedge clk);
        check({name, ".wrcnt"}, 32'(wr_cnt - wr0), 32'(ok));
        check({name, ".hold"}, 32'(err_code), 32'(code));
        check({name, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int acc;
        int wr0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.row", set_max_row, 32'd5);
        check("rst.col", set_max_col, 32'd5);
        check("rst.min", data_min, 32'd1);
        check("rst.max", data_max, 32'd9);
        check("rst.wr", 32'(wr_en), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd0);
        check("rst.code", 32'(err_code), 32'd0);

        // Stray valid while idle is not consumed.
        in_valid = 1'b1; in_data = 32'd77;
        @(negedge clk);
        check("idle.ready", 32'(in_ready), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);
        in_valid = 1'b0;

        txn("ok1",  32'd8, 32'd6, 32'hFFFF_FFFD, 32'd20, 0, 1, 2'd0,
            32'd8, 32'd6, 32'hFFFF_FFFD, 32'd20);
        txn("row0", 32'd0, 32'd4, 32'd1, 32'd2, 0, 0, 2'd1,
            32'd8, 32'd6, 32'hFFFF_FFFD, 32'd20);
        txn("row33", 32'd33, 32'd4, 32'd1, 32'd2, 0, 0, 2'd1,
            32'd8, 32'd6, 32'hFFFF_FFFD, 32'd20);
        txn("col33", 32'd4, 32'd33, 32'd10, 32'hFFFF_FFF6, 0, 0, 2'd1,
            32'd8, 32'd6, 32'hFFFF_FFFD, 32'd20);
        txn("order", 32'd4, 32'd4, 32'd10, 32'hFFFF_FFF6, 1, 0, 2'd2,
            32'd8, 32'd6, 32'hFFFF_FFFD, 32'd20);
        txn("limit", 32'd32, 32'd32, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 0, 1, 2'd0,
            32'd32, 32'd32, 32'hFFFF_FFF9, 32'hFFFF_FFF9);

`ifdef SETTINGS_WRITER_TIMEOUT_EN
        acc = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        in_valid = 1'b1; in_data = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c <= 40 && acc == 0; c++) begin
            if (error) acc = c;
            else @(negedge clk);
        end
        check("tmo.cycle", 32'(acc), 32'd16);
        check("tmo.code", 32'(err_code), 32'd3);
        check("tmo.busy", 32'(busy), 32'd0);
        txn("tmo_ok", 32'd2, 32'd3, 32'd4, 32'd5, 0, 1, 2'd0,
            32'd2, 32'd3, 32'd4, 32'd5);
`endif

        // Reset asserted in GET_MAX while in_valid toggles randomly.
        wr0 = wr_cnt;
        acc = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 200 && acc < 3; c++) begin
            logic r, v;
            r = in_ready;
            v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = $urandom;
            @(negedge clk);
            if (v && r) acc++;
        end
        check("rstm.words", 32'(acc), 32'd3);
        in_valid = 1'b1; in_data = 32'd1;
        #2 rst_n = 1'b0;
        #1;
        check("rstm.busy", 32'(busy), 32'd0);
        check("rstm.ready", 32'(in_ready), 32'd0);
        check("rstm.row", set_max_row, 32'd5);
        check("rstm.max", data_max, 32'd9);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstm.wrcnt", 32'(wr_cnt - wr0), 32'd0);
        txn("post", 32'd3, 32'd7, 32'd100, 32'd200, 0, 1, 2'd0,
            32'd3, 32'd7, 32'd100, 32'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
